mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage directly downstream of the ALU. Captures the ALU result, write-back flags and memory request.
//  Runs reads/writes of 1 or 2 bytes over a byte-wide request/ack bus, little-endian.
//  Presents the 16-bit write-back value plus rD/pc write flags to the register-file stage with a one-cycle done pulse.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles to wait for I_bus_ack per byte before abort with O_error (1..65535)
// PORTS
//  I_clk          in   1   clock, all state changes on posedge
//  I_reset_n      in   1   asynchronous, active-low reset
//  I_enable       in   1   start strobe; sampled only in IDLE
//  I_memory_mode  in   2   MEM_NOP / MEM_READ / MEM_WRITE (mem_acc.vh encoding)
//  I_memory_size  in   2   byte count: 2 = halfword, any other value = 1 byte
//  I_result       in   16  ALU result; memory address when mode is READ/WRITE
//  I_store_data   in   16  data to store (rB value) for MEM_WRITE
//  I_write_rD     in   1   ALU rD write flag
//  I_write_pc     in   1   ALU pc write flag
//  O_bus_req      out  1   bus request, held until ack
//  O_bus_we       out  1   1 = write byte, 0 = read byte
//  O_bus_addr     out  16  byte address
//  O_bus_wdata    out  8   write byte
//  I_bus_ack      in   1   bus acknowledge; read data valid in the same cycle
//  I_bus_rdata    in   8   read byte
//  O_busy         out  1   high in every state except IDLE
//  O_done         out  1   one-cycle pulse: O_data/O_write_rD/O_write_pc valid
//  O_data         out  16  write-back value
//  O_write_rD     out  1   registered rD write enable, qualified by O_done
//  O_write_pc     out  1   registered pc write enable, qualified by O_done
//  O_error        out  1   one-cycle pulse with O_done on bus timeout
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; internal counters/latches 0; a bus request in flight is dropped immediately.
//  All outputs are registered. States: IDLE, BYTE0, BYTE1, DONE.
//  IDLE, I_enable=1: latch all inputs.
//   - NOP -> DONE, O_data=I_result.
//   - READ/WRITE -> BYTE0, O_bus_req=1, O_bus_addr=I_result, O_bus_we=(mode==WRITE), O_bus_wdata=I_store_data[7:0].
//  IDLE, I_enable=0: stay.
//  BYTE0/BYTE1: req/addr/we/wdata stable until I_bus_ack sampled 1. Ack is ignored outside BYTE0/BYTE1.
//   - Read ack: capture I_bus_rdata into O_data[7:0] (BYTE0) or O_data[15:8] (BYTE1).
//   - BYTE0 ack, size==2: -> BYTE1, addr=latched addr+1 (16-bit wrap FFFF->0000), wdata=store[15:8]; req stays 1, no bubble.
//   - BYTE0 ack, size!=2 (or BYTE1 ack): req=0 -> DONE. 1-byte read zero-extends (O_data[15:8]=0).
//  Write: O_data=latched I_result (address); O_write_rD=0.
//  Timeout counter: cleared at each byte start and on each ack; +1 per cycle waiting.
//   - At TIMEOUT_CYCLES with no ack: req=0, -> DONE with O_error=1, O_write_rD=0, O_write_pc=0; O_data holds bytes captured so far.
//  DONE: O_done=1 for exactly one cycle, O_write_rD/O_write_pc=latched flags (forced 0 on error); -> IDLE.
//   - I_enable in DONE is ignored, and so is I_enable while O_busy=1.
//  O_write_rD/O_write_pc/O_error are 0 whenever O_done=0.
//  Latency, enable sampled at edge k:
//   - NOP: O_done high after edge k+1.
//   - Memory: req high after edge k; ack sampled at edge k+n -> next byte or DONE; O_done after DONE edge.
//   - 1-byte zero-wait access: O_done after edge k+2. 2-byte zero-wait access: after edge k+3.
//  Back-to-back: next I_enable accepted in the cycle after the O_done pulse, i.e. in IDLE.
// TESTING
//  1 NOP, I_result=16'h1234, rD=1 -> O_done after 1 cycle, O_data=1234, O_write_rD=1, no O_bus_req.
//  2 READ size 2 at addr FFFF, ack immediate, bytes AB then CD -> addresses FFFF then 0000, O_data=CDAB, O_write_rD=1.
//  3 WRITE size 2 at 0100, I_store_data=BEEF, ack delayed 3 cycles per byte -> EF@0100 then BE@0101, we=1, req/addr/data stable during waits, O_write_rD=0.
//  4 READ size 1 at 0040, rdata=F0 -> O_data=00F0; I_enable pulses while busy are ignored, with no extra bus traffic.
//  5 TIMEOUT_CYCLES=4, no ack -> req drops after 4 wait cycles, O_done=1 with O_error=1, O_write_rD=0.
//  6 I_reset_n low in BYTE1 -> O_bus_req/O_busy 0 without a clock edge; next enable starts a clean transaction.

Source files
------------

// File: rtl/mem_access.sv
// Memory stage after the ALU: runs 1- or 2-byte little-endian accesses over a
// byte-wide req/ack bus, then hands the write-back value and flags to the
// register-file stage with a one-cycle done pulse.
`timescale 1ns/1ps
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_enable,
  input  logic [1:0]  I_memory_mode,
  input  logic [1:0]  I_memory_size,
  input  logic [15:0] I_result,
  input  logic [15:0] I_store_data,
  input  logic        I_write_rD,
  input  logic        I_write_pc,
  output logic        O_bus_req,
  output logic        O_bus_we,
  output logic [15:0] O_bus_addr,
  output logic [7:0]  O_bus_wdata,
  input  logic        I_bus_ack,
  input  logic [7:0]  I_bus_rdata,
  output logic        O_busy,
  output logic        O_done,
  output logic [15:0] O_data,
  output logic        O_write_rD,
  output logic        O_write_pc,
  output logic        O_error
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 16;

  // Memory mode encoding; any mode other than READ/WRITE behaves as NOP.
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  // Last wait count before a byte is abandoned.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BYTE0, S_BYTE1, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   store_hi_q, store_hi_d;
  logic            size2_q, size2_d;
  logic            rd_flag_q, rd_flag_d;
  logic            pc_flag_q, pc_flag_d;
  logic            err_q, err_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            out_rd_q, out_rd_d;
  logic            out_pc_q, out_pc_d;
  logic            out_err_q, out_err_d;

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    store_hi_d = store_hi_q;
    size2_d    = size2_q;
    rd_flag_d  = rd_flag_q;
    pc_flag_d  = pc_flag_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    out_rd_d   = 1'b0;
    out_pc_d   = 1'b0;
    out_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (I_enable) begin
          // A store never writes rD; its write-back value is the address.
          rd_flag_d  = I_write_rD & (I_memory_mode != MEM_WRITE);
          pc_flag_d  = I_write_pc;
          err_d      = 1'b0;
          size2_d    = (I_memory_size == 2'd2);
          store_hi_d = I_store_data[15:8];
          tcnt_d     = '0;
          if ((I_memory_mode == MEM_READ) || (I_memory_mode == MEM_WRITE)) begin
            state_d = S_BYTE0;
            req_d   = 1'b1;
            we_d    = (I_memory_mode == MEM_WRITE);
            addr_d  = I_result;
            wdata_d = I_store_data[7:0];
            data_d  = (I_memory_mode == MEM_WRITE) ? I_result : '0;
          end else begin
            state_d = S_DONE;
            data_d  = I_result;
          end
        end
      end
      S_BYTE0, S_BYTE1: begin
        if (I_bus_ack) begin
          tcnt_d = '0;
          if (!we_q) begin
            if (state_q == S_BYTE0) data_d[7:0]  = I_bus_rdata;
            else                    data_d[15:8] = I_bus_rdata;
          end
          if ((state_q == S_BYTE0) && size2_q) begin
            // Second byte follows with no bubble on req.
            state_d = S_BYTE1;
            addr_d  = addr_q + AW'(1);
            wdata_d = store_hi_q;
          end else begin
            req_d   = 1'b0;
            state_d = S_DONE;
          end
        end else if (tcnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        out_rd_d  = rd_flag_q & ~err_q;
        out_pc_d  = pc_flag_q & ~err_q;
        out_err_d = err_q;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight request at once.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      store_hi_q <= '0;
      size2_q    <= 1'b0;
      rd_flag_q  <= 1'b0;
      pc_flag_q  <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_rd_q   <= 1'b0;
      out_pc_q   <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      store_hi_q <= store_hi_d;
      size2_q    <= size2_d;
      rd_flag_q  <= rd_flag_d;
      pc_flag_q  <= pc_flag_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_rd_q   <= out_rd_d;
      out_pc_q   <= out_pc_d;
      out_err_q  <= out_err_d;
    end
  end

  assign O_bus_req   = req_q;
  assign O_bus_we    = we_q;
  assign O_bus_addr  = addr_q;
  assign O_bus_wdata = wdata_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_data      = data_q;
  assign O_write_rD  = out_rd_q;
  assign O_write_pc  = out_pc_q;
  assign O_error     = out_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected write-back results are queued when
// each access starts and popped when O_done is seen.
`timescale 1ns/1ps
module tb_mem_access;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  logic        I_clk = 1'b0;
  logic        I_reset_n = 1'b0;
  logic        I_enable = 1'b0;
  logic [1:0]  I_memory_mode = 2'd0;
  logic [1:0]  I_memory_size = 2'd0;
  logic [15:0] I_result = 16'h0;
  logic [15:0] I_store_data = 16'h0;
  logic        I_write_rD = 1'b0;
  logic        I_write_pc = 1'b0;
  logic        O_bus_req;
  logic        O_bus_we;
  logic [15:0] O_bus_addr;
  logic [7:0]  O_bus_wdata;
  logic        I_bus_ack = 1'b0;
  logic [7:0]  I_bus_rdata = 8'h0;
  logic        O_busy;
  logic        O_done;
  logic [15:0] O_data;
  logic        O_write_rD;
  logic        O_write_pc;
  logic        O_error;

  typedef struct packed {
    logic [15:0] data;
    logic        rd;
    logic        pc;
    logic        err;
  } wb_t;

  wb_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   bus_starts = 0;
  int   base = 0;
  logic req_prev = 1'b0;

  always #5 I_clk = ~I_clk;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .I_enable(I_enable),
    .I_memory_mode(I_memory_mode), .I_memory_size(I_memory_size),
    .I_result(I_result), .I_store_data(I_store_data),
    .I_write_rD(I_write_rD), .I_write_pc(I_write_pc),
    .O_bus_req(O_bus_req), .O_bus_we(O_bus_we), .O_bus_addr(O_bus_addr),
    .O_bus_wdata(O_bus_wdata), .I_bus_ack(I_bus_ack), .I_bus_rdata(I_bus_rdata),
    .O_busy(O_busy), .O_done(O_done), .O_data(O_data),
    .O_write_rD(O_write_rD), .O_write_pc(O_write_pc), .O_error(O_error)
  );

  always @(posedge I_clk) cyc <= cyc + 1;

  // Count bus transactions by rising edges of the request.
  always @(negedge I_clk) begin
    if (O_bus_req && !req_prev) bus_starts = bus_starts + 1;
    req_prev = O_bus_req;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] mode, input logic [1:0] size,
                       input logic [15:0] res, input logic [15:0] st,
                       input logic rd, input logic pc, input wb_t exp);
    I_memory_mode = mode;
    I_memory_size = size;
    I_result      = res;
    I_store_data  = st;
    I_write_rD    = rd;
    I_write_pc    = pc;
    I_enable      = 1'b1;
    exp_q.push_back(exp);
    @(negedge I_clk);
    t0 = cyc;
    I_enable      = 1'b0;
    I_result      = 16'($urandom);
    I_store_data  = 16'($urandom);
    I_write_rD    = 1'($urandom);
    I_write_pc    = 1'($urandom);
    I_memory_size = 2'($urandom);
  endtask

  task automatic serve(input string tag, input logic we, input logic [15:0] addr,
                       input logic [7:0] wd, input int dly, input logic [7:0] rdat,
                       input logic poke);
    check(tag, 64'({O_bus_req, O_bus_we, O_bus_addr, O_bus_wdata}),
          64'({1'b1, we, addr, wd}));
    for (int i = 0; i < dly; i++) begin
      I_bus_ack   = 1'b0;
      I_bus_rdata = 8'($urandom);
      if (poke) begin
        I_enable      = 1'b1;
        I_memory_mode = 2'($urandom);
        I_result      = 16'($urandom);
      end
      @(negedge I_clk);
      I_enable = 1'b0;
      check({tag, " stable"}, 64'({O_bus_req, O_bus_we, O_bus_addr, O_bus_wdata}),
            64'({1'b1, we, addr, wd}));
    end
    I_bus_ack   = 1'b1;
    I_bus_rdata = rdat;
    @(negedge I_clk);
    I_bus_ack   = 1'b0;
    I_bus_rdata = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int  n = 0;
    wb_t e;
    while (O_done !== 1'b1 && n < 100) begin
      @(negedge I_clk);
      n++;
    end
    check({tag, " done"}, 64'(O_done), 64'(1));
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " wb"}, 64'({O_data, O_write_rD, O_write_pc, O_error}), 64'(e));
    end
    check({tag, " latency"}, 64'(cyc - t0), 64'(exp_lat));
    @(negedge I_clk);
    check({tag, " pulse"}, 64'({O_done, O_write_rD, O_write_pc, O_error, O_busy}), 64'(0));
  endtask

  // Guard against a hung DUT handshake.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    I_reset_n = 1'b0;
    repeat (2) @(negedge I_clk);
    check("reset", 64'({O_bus_req, O_bus_we, O_bus_addr, O_bus_wdata, O_busy, O_done,
                        O_data, O_write_rD, O_write_pc, O_error}), 64'(0));
    I_reset_n = 1'b1;
    @(negedge I_clk);

    // NOP: result passes straight through, no bus activity.
    base = bus_starts;
    start(MEM_NOP, 2'd0, 16'h1234, 16'h0, 1'b1, 1'b0, wb_t'{16'h1234, 1'b1, 1'b0, 1'b0});
    check("t1 busy", 64'(O_busy), 64'(1));
    wait_done("t1", 1);
    check("t1 no bus", 64'(bus_starts), 64'(base));

    // NOP with pc write.
    start(MEM_NOP, 2'd2, 16'h0000, 16'h0, 1'b0, 1'b1, wb_t'{16'h0000, 1'b0, 1'b1, 1'b0});
    wait_done("t1b", 1);

    // Halfword read across the address wrap.
    start(MEM_READ, 2'd2, 16'hFFFF, 16'h5566, 1'b1, 1'b0, wb_t'{16'hCDAB, 1'b1, 1'b0, 1'b0});
    serve("t2 b0", 1'b0, 16'hFFFF, 8'h66, 0, 8'hAB, 1'b0);
    serve("t2 b1", 1'b0, 16'h0000, 8'h55, 0, 8'hCD, 1'b0);
    wait_done("t2", 3);

    // Halfword write, three wait cycles per byte (one short of timeout).
    start(MEM_WRITE, 2'd2, 16'h0100, 16'hBEEF, 1'b1, 1'b0, wb_t'{16'h0100, 1'b0, 1'b0, 1'b0});
    serve("t3 b0", 1'b1, 16'h0100, 8'hEF, 3, 8'h00, 1'b0);
    serve("t3 b1", 1'b1, 16'h0101, 8'hBE, 3, 8'h00, 1'b0);
    wait_done("t3", 9);

    // Byte read with enable pokes while busy and in DONE.
    base = bus_starts;
    start(MEM_READ, 2'd1, 16'h0040, 16'h1234, 1'b1, 1'b1, wb_t'{16'h00F0, 1'b1, 1'b1, 1'b0});
    serve("t4 b0", 1'b0, 16'h0040, 8'h34, 2, 8'hF0, 1'b1);
    I_enable      = 1'b1;
    I_memory_mode = MEM_NOP;
    @(negedge I_clk);
    I_enable = 1'b0;
    wait_done("t4", 4);
    check("t4 one txn", 64'(bus_starts), 64'(base + 1));

    // Timeout on the second byte of a halfword read.
    start(MEM_READ, 2'd2, 16'h8000, 16'h0000, 1'b1, 1'b1, wb_t'{16'h005A, 1'b0, 1'b0, 1'b1});
    serve("t5 b0", 1'b0, 16'h8000, 8'h00, 0, 8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t5 waiting req", 64'(O_bus_req), 64'(1));
      @(negedge I_clk);
    end
    check("t5 req dropped", 64'({O_bus_req, O_busy}), 64'(2'b01));
    wait_done("t5", 6);

    // Asynchronous reset in the middle of a halfword read.
    start(MEM_READ, 2'd2, 16'h2000, 16'hA1B2, 1'b1, 1'b0, wb_t'{16'h0000, 1'b0, 1'b0, 1'b0});
    serve("t6 b0", 1'b0, 16'h2000, 8'hB2, 0, 8'h11, 1'b0);
    check("t6 in byte1", 64'({O_bus_req, O_bus_addr}), 64'({1'b1, 16'h2001}));
    #2 I_reset_n = 1'b0;
    #1 check("t6 async reset", 64'({O_bus_req, O_busy, O_done, O_data, O_bus_addr}), 64'(0));
    exp_q.delete();
    @(negedge I_clk);
    I_reset_n = 1'b1;
    @(negedge I_clk);
    start(MEM_WRITE, 2'd0, 16'h3000, 16'h0077, 1'b1, 1'b1, wb_t'{16'h3000, 1'b0, 1'b1, 1'b0});
    serve("t6 clean", 1'b1, 16'h3000, 8'h77, 0, 8'h00, 1'b0);
    wait_done("t6", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
